sal_bank_ctrl: RTL and testbench



---
 rtl/sal_ddr2_pkg.sv | 42 ++++
 rtl/sal_bank_ctrl_if.sv | 43 ++++
 rtl/sal_timing_cnt.sv | 37 +++
 rtl/sal_bank_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_sal_bank_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sal_ddr2_pkg.sv
// Shared types for the SAL DDR2 per-bank controller.
//   cmd_op_e     : command code driven to the channel scheduler (ACT/PRE/RD/WR)
//   bank_state_e : bank FSM states
//   req_t/cmd_t  : request and command records at the default field widths
package sal_ddr2_pkg;

    localparam int unsigned DefIdWidth  = 4;
    localparam int unsigned DefRaWidth  = 14;
    localparam int unsigned DefCaWidth  = 10;
    localparam int unsigned DefLenWidth = 4;

    typedef enum logic [1:0] {
        CmdAct = 2'd0,
        CmdPre = 2'd1,
        CmdRd  = 2'd2,
        CmdWr  = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        StClosed,
        StActivating,
        StOpen,
        StPrecharging
    } bank_state_e;

    typedef struct packed {
        logic [DefIdWidth-1:0]  id;
        logic [DefRaWidth-1:0]  ra;
        logic [DefCaWidth-1:0]  ca;
        logic [DefLenWidth-1:0] len;
        logic                   wr;
    } req_t;

    typedef struct packed {
        cmd_op_e                op;
        logic [DefIdWidth-1:0]  id;
        logic [DefRaWidth-1:0]  ra;
        logic [DefCaWidth-1:0]  ca;
        logic [DefLenWidth-1:0] len;
    } cmd_t;

endpackage

// File: rtl/sal_bank_ctrl_if.sv
// Bus bundle of one bank controller.
//   req_*   : request stream from the address decoder (valid/ready)
//   cmd_*   : DRAM commands to the channel scheduler (valid/ready)
//   ref_req : refresh request (level), ref_gnt : bank parked and idle
// Modports: slave = bank controller, master = decoder/scheduler/refresh side.
interface sal_bank_ctrl_if #(
    parameter int unsigned ID_WIDTH  = sal_ddr2_pkg::DefIdWidth,
    parameter int unsigned RA_WIDTH  = sal_ddr2_pkg::DefRaWidth,
    parameter int unsigned CA_WIDTH  = sal_ddr2_pkg::DefCaWidth,
    parameter int unsigned LEN_WIDTH = sal_ddr2_pkg::DefLenWidth
);
    import sal_ddr2_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [ID_WIDTH-1:0]  req_id;
    logic [RA_WIDTH-1:0]  req_ra;
    logic [CA_WIDTH-1:0]  req_ca;
    logic [LEN_WIDTH-1:0] req_len;
    logic                 req_wr;

    logic                 cmd_valid;
    logic                 cmd_ready;
    cmd_op_e              cmd_op;
    logic [ID_WIDTH-1:0]  cmd_id;
    logic [RA_WIDTH-1:0]  cmd_ra;
    logic [CA_WIDTH-1:0]  cmd_ca;
    logic [LEN_WIDTH-1:0] cmd_len;

    logic                 ref_req;
    logic                 ref_gnt;

    modport slave (
        input  req_valid, req_id, req_ra, req_ca, req_len, req_wr, cmd_ready, ref_req,
        output req_ready, cmd_valid, cmd_op, cmd_id, cmd_ra, cmd_ca, cmd_len, ref_gnt
    );

    modport master (
        output req_valid, req_id, req_ra, req_ca, req_len, req_wr, cmd_ready, ref_req,
        input  req_ready, cmd_valid, cmd_op, cmd_id, cmd_ra, cmd_ca, cmd_len, ref_gnt
    );

endinterface

// File: rtl/sal_timing_cnt.sv
// Saturating timing down-counter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_val_i this cycle (wins over decrement)
//   load_val_i  : value to load (T-1 for a T-cycle constraint)
//   is_zero_o   : counter has expired
module sal_timing_cnt #(
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    output logic                 is_zero_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/sal_bank_ctrl.sv
// Per-bank DRAM controller: buffers one request, tracks the open row, enforces
// tRCD/tRP/tRAS/tRTP/tWTP and issues ACT/PRE/RD/WR to the scheduler.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sal_bank_ctrl_if.slave (request in, command out, refresh)
// Build option: SAL_BK_CLOSED_PAGE_EN defined -> precharge an idle open row as
// soon as timing allows; undefined -> row stays open until a miss or refresh.
module sal_bank_ctrl
    import sal_ddr2_pkg::*;
#(
    parameter int unsigned ID_WIDTH  = DefIdWidth,
    parameter int unsigned RA_WIDTH  = DefRaWidth,
    parameter int unsigned CA_WIDTH  = DefCaWidth,
    parameter int unsigned LEN_WIDTH = DefLenWidth,
    parameter int unsigned CNT_WIDTH = 4,
    parameter int unsigned T_RCD     = 3,
    parameter int unsigned T_RP      = 3,
    parameter int unsigned T_RAS     = 8,
    parameter int unsigned T_RTP     = 2,
    parameter int unsigned T_WTP     = 6
) (
    input logic           clk,
    input logic           rst_n,
    sal_bank_ctrl_if.slave bus
);

`ifdef SAL_BK_CLOSED_PAGE_EN
    localparam bit ClosedPage = 1'b1;
`else
    localparam bit ClosedPage = 1'b0;
`endif

    bank_state_e          state_q, state_d;
    logic                 buf_valid_q, buf_valid_d;
    logic [ID_WIDTH-1:0]  buf_id_q, buf_id_d;
    logic [RA_WIDTH-1:0]  buf_ra_q, buf_ra_d;
    logic [CA_WIDTH-1:0]  buf_ca_q, buf_ca_d;
    logic [LEN_WIDTH-1:0] buf_len_q, buf_len_d;
    logic                 buf_wr_q, buf_wr_d;
    logic [RA_WIDTH-1:0]  open_row_q, open_row_d;

    // Captured command while the scheduler stalls, so valid/payload stay put.
    logic                 hold_q, hold_d;
    cmd_op_e              hold_op_q, hold_op_d;
    logic [ID_WIDTH-1:0]  hold_id_q, hold_id_d;
    logic [RA_WIDTH-1:0]  hold_ra_q, hold_ra_d;
    logic [CA_WIDTH-1:0]  hold_ca_q, hold_ca_d;
    logic [LEN_WIDTH-1:0] hold_len_q, hold_len_d;

    logic                 f_valid;
    cmd_op_e              f_op;
    logic [ID_WIDTH-1:0]  f_id;
    logic [RA_WIDTH-1:0]  f_ra;
    logic [CA_WIDTH-1:0]  f_ca;
    logic [LEN_WIDTH-1:0] f_len;

    logic                 cmd_valid;
    cmd_op_e              cmd_op;
    logic [ID_WIDTH-1:0]  cmd_id;
    logic [RA_WIDTH-1:0]  cmd_ra;
    logic [CA_WIDTH-1:0]  cmd_ca;
    logic [LEN_WIDTH-1:0] cmd_len;

    logic req_ready, req_fire, cmd_fire, row_hit, col_ok, pre_ok;
    logic act_fire, pre_fire, rd_fire, wr_fire;
    logic rcd_zero, rp_zero, ras_zero, rtp_zero, wtp_zero;

    always_comb begin
        req_ready = !buf_valid_q && !bus.ref_req;
        req_fire  = bus.req_valid && req_ready;
        row_hit   = (buf_ra_q == open_row_q);
        // Column commands may go out in the very cycle tRCD expires.
        col_ok    = (state_q == StOpen) || ((state_q == StActivating) && rcd_zero);
        pre_ok    = ras_zero && rtp_zero && wtp_zero;

        f_valid = 1'b0;
        f_op    = CmdAct;
        f_id    = '0;
        f_ra    = '0;
        f_ca    = '0;
        f_len   = '0;
        if ((state_q == StClosed) && buf_valid_q) begin
            f_valid = 1'b1;
            f_ra    = buf_ra_q;
        end else if (col_ok && buf_valid_q && row_hit) begin
            f_valid = 1'b1;
            f_op    = buf_wr_q ? CmdWr : CmdRd;
            f_id    = buf_id_q;
            f_ra    = buf_ra_q;
            f_ca    = buf_ca_q;
            f_len   = buf_len_q;
        end else if ((state_q == StOpen) && pre_ok &&
                     (buf_valid_q ? !row_hit : (bus.ref_req || ClosedPage))) begin
            f_valid = 1'b1;
            f_op    = CmdPre;
            f_ra    = open_row_q;
        end

        cmd_valid = hold_q || f_valid;
        cmd_op    = hold_q ? hold_op_q  : f_op;
        cmd_id    = hold_q ? hold_id_q  : f_id;
        cmd_ra    = hold_q ? hold_ra_q  : f_ra;
        cmd_ca    = hold_q ? hold_ca_q  : f_ca;
        cmd_len   = hold_q ? hold_len_q : f_len;

        cmd_fire = cmd_valid && bus.cmd_ready;
        act_fire = cmd_fire && (cmd_op == CmdAct);
        pre_fire = cmd_fire && (cmd_op == CmdPre);
        rd_fire  = cmd_fire && (cmd_op == CmdRd);
        wr_fire  = cmd_fire && (cmd_op == CmdWr);

        hold_d     = cmd_valid && !bus.cmd_ready;
        hold_op_d  = cmd_op;
        hold_id_d  = cmd_id;
        hold_ra_d  = cmd_ra;
        hold_ca_d  = cmd_ca;
        hold_len_d = cmd_len;

        state_d = state_q;
        case (state_q)
            StClosed:      if (act_fire) state_d = StActivating;
            StActivating:  if (rcd_zero) state_d = StOpen;
            StOpen:        if (pre_fire) state_d = StPrecharging;
            StPrecharging: if (rp_zero)  state_d = StClosed;
            default:       state_d = StClosed;
        endcase

        open_row_d  = act_fire ? cmd_ra : open_row_q;
        buf_valid_d = buf_valid_q;
        buf_id_d    = buf_id_q;
        buf_ra_d    = buf_ra_q;
        buf_ca_d    = buf_ca_q;
        buf_len_d   = buf_len_q;
        buf_wr_d    = buf_wr_q;
        if (rd_fire || wr_fire) begin
            buf_valid_d = 1'b0;
        end else if (req_fire) begin
            buf_valid_d = 1'b1;
            buf_id_d    = bus.req_id;
            buf_ra_d    = bus.req_ra;
            buf_ca_d    = bus.req_ca;
            buf_len_d   = bus.req_len;
            buf_wr_d    = bus.req_wr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StClosed;
            buf_valid_q <= 1'b0;
            buf_id_q    <= '0;
            buf_ra_q    <= '0;
            buf_ca_q    <= '0;
            buf_len_q   <= '0;
            buf_wr_q    <= 1'b0;
            open_row_q  <= '0;
            hold_q      <= 1'b0;
            hold_op_q   <= CmdAct;
            hold_id_q   <= '0;
            hold_ra_q   <= '0;
            hold_ca_q   <= '0;
            hold_len_q  <= '0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_id_q    <= buf_id_d;
            buf_ra_q    <= buf_ra_d;
            buf_ca_q    <= buf_ca_d;
            buf_len_q   <= buf_len_d;
            buf_wr_q    <= buf_wr_d;
            open_row_q  <= open_row_d;
            hold_q      <= hold_d;
            hold_op_q   <= hold_op_d;
            hold_id_q   <= hold_id_d;
            hold_ra_q   <= hold_ra_d;
            hold_ca_q   <= hold_ca_d;
            hold_len_q  <= hold_len_d;
        end
    end

    sal_timing_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_rcd_cnt (
        .clk(clk), .rst_n(rst_n), .load_i(act_fire),
        .load_val_i(CNT_WIDTH'(T_RCD - 1)), .is_zero_o(rcd_zero)
    );
    sal_timing_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_ras_cnt (
        .clk(clk), .rst_n(rst_n), .load_i(act_fire),
        .load_val_i(CNT_WIDTH'(T_RAS - 1)), .is_zero_o(ras_zero)
    );
    sal_timing_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_rp_cnt (
        .clk(clk), .rst_n(rst_n), .load_i(pre_fire),
        .load_val_i(CNT_WIDTH'(T_RP - 1)), .is_zero_o(rp_zero)
    );
    sal_timing_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_rtp_cnt (
        .clk(clk), .rst_n(rst_n), .load_i(rd_fire),
        .load_val_i(CNT_WIDTH'(T_RTP - 1)), .is_zero_o(rtp_zero)
    );
    sal_timing_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_wtp_cnt (
        .clk(clk), .rst_n(rst_n), .load_i(wr_fire),
        .load_val_i(CNT_WIDTH'(T_WTP - 1)), .is_zero_o(wtp_zero)
    );

    assign bus.req_ready = req_ready;
    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_op    = cmd_op;
    assign bus.cmd_id    = cmd_id;
    assign bus.cmd_ra    = cmd_ra;
    assign bus.cmd_ca    = cmd_ca;
    assign bus.cmd_len   = cmd_len;
    assign bus.ref_gnt   = (state_q == StClosed) && !buf_valid_q && bus.ref_req;

endmodule

// File: tb/tb_sal_bank_ctrl.sv
// Bench for sal_bank_ctrl: expected commands are queued as stimulus is driven
// and compared against the command handshakes seen on the bus.
module tb_sal_bank_ctrl;
    import sal_ddr2_pkg::*;

    typedef struct {
        cmd_t c;
        int   edge_n;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sal_bank_ctrl_if bus ();

    sal_bank_ctrl u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int   cyc = 0;
    int   vec = 0;
    int   mis = 0;
    cmd_t exp_q[$];
    obs_t obs_q[$];
    int   acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes seen at the falling edge complete on the next rising edge.
    always @(negedge clk) begin : mon
        obs_t o;
        if (rst_n) begin
            if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc + 1);
            if (bus.cmd_valid && bus.cmd_ready) begin
                o.c.op  = bus.cmd_op;
                o.c.id  = bus.cmd_id;
                o.c.ra  = bus.cmd_ra;
                o.c.ca  = bus.cmd_ca;
                o.c.len = bus.cmd_len;
                o.edge_n = cyc + 1;
                obs_q.push_back(o);
            end
        end
    end

    function automatic cmd_t mk_cmd(cmd_op_e op, logic [DefIdWidth-1:0] id,
                                    logic [DefRaWidth-1:0] ra, logic [DefCaWidth-1:0] ca,
                                    logic [DefLenWidth-1:0] len);
        cmd_t c;
        c.op = op; c.id = id; c.ra = ra; c.ca = ca; c.len = len;
        return c;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_id = '0; bus.req_ra = '0; bus.req_ca = '0; bus.req_len = '0; bus.req_wr = 1'b0;
        bus.cmd_ready = 1'b1;
        bus.ref_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete(); obs_q.delete(); acc_q.delete();
    endtask

    task automatic send_req(input logic [3:0] id, input logic [13:0] ra, input logic [9:0] ca,
                            input logic [3:0] len, input logic wr);
        bit got = 1'b0;
        @(posedge clk);
        #1;
        bus.req_id = id; bus.req_ra = ra; bus.req_ca = ca; bus.req_len = len; bus.req_wr = wr;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        if (!got) begin
            vec++; mis++;
            $display("FAIL send_req: req_ready never seen, got 0 want 1");
        end
    endtask

    task automatic wait_obs(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vec++; if (bus.req_ready !== 1'b1) begin mis++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
        vec++; if (bus.cmd_valid !== 1'b0) begin mis++; $display("FAIL rst_cmd_valid: got %b want 0", bus.cmd_valid); end
        vec++; if (bus.ref_gnt !== 1'b0) begin mis++; $display("FAIL rst_ref_gnt: got %b want 0", bus.ref_gnt); end
        // Leave an ACT stalled, then reset asynchronously mid-cycle.
        bus.cmd_ready = 1'b0;
        send_req(4'h6, 14'h0123, 10'h045, 4'h3, 1'b1);
        @(negedge clk);
        vec++; if (bus.cmd_valid !== 1'b1) begin mis++; $display("FAIL mid_cmd_valid: got %b want 1", bus.cmd_valid); end
        #2 rst_n = 1'b0;
        #1;
        vec++; if (bus.cmd_valid !== 1'b0) begin mis++; $display("FAIL arst_cmd_valid: got %b want 0", bus.cmd_valid); end
        vec++; if (bus.cmd_op !== CmdAct) begin mis++; $display("FAIL arst_cmd_op: got %0d want 0", bus.cmd_op); end
        vec++; if ({bus.cmd_id, bus.cmd_ra, bus.cmd_ca, bus.cmd_len} !== '0) begin
            mis++; $display("FAIL arst_payload: got %h want 0", {bus.cmd_id, bus.cmd_ra, bus.cmd_ca, bus.cmd_len});
        end
        vec++; if (bus.req_ready !== 1'b1) begin mis++; $display("FAIL arst_req_ready: got %b want 1", bus.req_ready); end
        vec++; if (bus.ref_gnt !== 1'b0) begin mis++; $display("FAIL arst_ref_gnt: got %b want 0", bus.ref_gnt); end
    endtask

    task automatic test_read_closed();
        bit ok; obs_t o; cmd_t e; int ed[2];
        apply_reset();
        exp_q.push_back(mk_cmd(CmdAct, 4'h0, 14'd5, 10'd0, 4'h0));
        exp_q.push_back(mk_cmd(CmdRd, 4'h3, 14'd5, 10'd16, 4'h4));
        send_req(4'h3, 14'd5, 10'd16, 4'h4, 1'b0);
        wait_obs(2, ok);
        if (!ok) begin
            vec++; mis++; $display("FAIL read_closed: got %0d cmds want 2", obs_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                o = obs_q.pop_front(); e = exp_q.pop_front(); ed[i] = o.edge_n; vec++;
                if (o.c !== e) begin mis++; $display("FAIL read_closed cmd%0d: got %h want %h", i, o.c, e); end
            end
            vec++; if (ed[1] - ed[0] != 3) begin mis++; $display("FAIL read_closed rcd: got %0d want 3", ed[1] - ed[0]); end
            vec++; if (acc_q.size() != 1 || ed[0] != acc_q[0] + 1) begin
                mis++; $display("FAIL read_closed act_latency: got edge %0d want acc+1 (%0d accepts)", ed[0], acc_q.size());
            end
        end
    endtask

    task automatic test_row_hit();
        bit ok; obs_t o; cmd_t e;
        apply_reset();
        exp_q.push_back(mk_cmd(CmdAct, 4'h0, 14'd5, 10'd0, 4'h0));
        exp_q.push_back(mk_cmd(CmdWr, 4'h1, 14'd5, 10'd0, 4'h2));
        exp_q.push_back(mk_cmd(CmdWr, 4'h2, 14'd5, 10'd8, 4'h2));
        send_req(4'h1, 14'd5, 10'd0, 4'h2, 1'b1);
        send_req(4'h2, 14'd5, 10'd8, 4'h2, 1'b1);
        wait_obs(3, ok);
        if (!ok) begin
            vec++; mis++; $display("FAIL row_hit: got %0d cmds want 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                o = obs_q.pop_front(); e = exp_q.pop_front(); vec++;
                if (o.c !== e) begin mis++; $display("FAIL row_hit cmd%0d: got %h want %h", i, o.c, e); end
            end
            repeat (30) @(posedge clk);
            vec++; if (obs_q.size() != 0) begin mis++; $display("FAIL row_hit extra_cmds: got %0d want 0", obs_q.size()); end
        end
    endtask

    task automatic test_row_miss();
        bit ok; obs_t o; cmd_t e; int ed[5];
        apply_reset();
        exp_q.push_back(mk_cmd(CmdAct, 4'h0, 14'd5, 10'd0, 4'h0));
        exp_q.push_back(mk_cmd(CmdRd, 4'h1, 14'd5, 10'd1, 4'h1));
        exp_q.push_back(mk_cmd(CmdPre, 4'h0, 14'd5, 10'd0, 4'h0));
        exp_q.push_back(mk_cmd(CmdAct, 4'h0, 14'd9, 10'd0, 4'h0));
        exp_q.push_back(mk_cmd(CmdRd, 4'h2, 14'd9, 10'd2, 4'h1));
        send_req(4'h1, 14'd5, 10'd1, 4'h1, 1'b0);
        send_req(4'h2, 14'd9, 10'd2, 4'h1, 1'b0);
        wait_obs(5, ok);
        if (!ok) begin
            vec++; mis++; $display("FAIL row_miss: got %0d cmds want 5", obs_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                o = obs_q.pop_front(); e = exp_q.pop_front(); ed[i] = o.edge_n; vec++;
                if (o.c !== e) begin mis++; $display("FAIL row_miss cmd%0d: got %h want %h", i, o.c, e); end
            end
            vec++; if (ed[2] - ed[0] != 8) begin mis++; $display("FAIL row_miss ras: got %0d want 8", ed[2] - ed[0]); end
            vec++; if (ed[3] - ed[2] < 3) begin mis++; $display("FAIL row_miss rp: got %0d want >=3", ed[3] - ed[2]); end
            vec++; if (ed[4] - ed[3] != 3) begin mis++; $display("FAIL row_miss rcd2: got %0d want 3", ed[4] - ed[3]); end
        end
    endtask

    task automatic test_refresh();
        bit ok; obs_t o; cmd_t e; int p;
        apply_reset();
        exp_q.push_back(mk_cmd(CmdAct, 4'h0, 14'd5, 10'd0, 4'h0));
        exp_q.push_back(mk_cmd(CmdRd, 4'h1, 14'd5, 10'd2, 4'h1));
        exp_q.push_back(mk_cmd(CmdPre, 4'h0, 14'd5, 10'd0, 4'h0));
        send_req(4'h1, 14'd5, 10'd2, 4'h1, 1'b0);
        wait_obs(2, ok);
        #1 bus.ref_req = 1'b1;
        @(negedge clk);
        vec++; if (bus.req_ready !== 1'b0) begin mis++; $display("FAIL ref_req_ready: got %b want 0", bus.req_ready); end
        wait_obs(3, ok);
        if (!ok) begin
            vec++; mis++; $display("FAIL refresh: got %0d cmds want 3", obs_q.size());
            bus.ref_req = 1'b0;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); vec++;
            if (o.c !== e) begin mis++; $display("FAIL refresh cmd%0d: got %h want %h", i, o.c, e); end
        end
        p = o.edge_n;
        while (cyc < p + 2) @(negedge clk);
        vec++; if (bus.ref_gnt !== 1'b0) begin mis++; $display("FAIL ref_gnt_early: got %b want 0", bus.ref_gnt); end
        @(negedge clk);
        vec++; if (bus.ref_gnt !== 1'b1) begin mis++; $display("FAIL ref_gnt_pre3: got %b want 1", bus.ref_gnt); end
        // Request collides with refresh: not accepted until refresh drops.
        acc_q.delete();
        exp_q.push_back(mk_cmd(CmdAct, 4'h0, 14'd9, 10'd0, 4'h0));
        exp_q.push_back(mk_cmd(CmdRd, 4'h7, 14'd9, 10'd3, 4'h2));
        @(posedge clk);
        #1;
        bus.req_id = 4'h7; bus.req_ra = 14'd9; bus.req_ca = 10'd3; bus.req_len = 4'h2; bus.req_wr = 1'b0;
        bus.req_valid = 1'b1;
        @(negedge clk);
        vec++; if (bus.req_ready !== 1'b0) begin mis++; $display("FAIL ref_collide_ready: got %b want 0", bus.req_ready); end
        @(posedge clk);
        #1 bus.ref_req = 1'b0;
        @(negedge clk);
        vec++; if (bus.ref_gnt !== 1'b0) begin mis++; $display("FAIL ref_drop_gnt: got %b want 0", bus.ref_gnt); end
        vec++; if (bus.req_ready !== 1'b1) begin mis++; $display("FAIL ref_drop_ready: got %b want 1", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        vec++; if (acc_q.size() != 1) begin mis++; $display("FAIL ref_collide_accepts: got %0d want 1", acc_q.size()); end
        wait_obs(2, ok);
        if (!ok) begin
            vec++; mis++; $display("FAIL refresh_reopen: got %0d cmds want 2", obs_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                o = obs_q.pop_front(); e = exp_q.pop_front(); vec++;
                if (o.c !== e) begin mis++; $display("FAIL refresh_reopen cmd%0d: got %h want %h", i, o.c, e); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok; obs_t o; cmd_t e; int n;
        apply_reset();
        bus.cmd_ready = 1'b0;
        exp_q.push_back(mk_cmd(CmdAct, 4'h0, 14'd7, 10'd0, 4'h0));
        exp_q.push_back(mk_cmd(CmdRd, 4'h4, 14'd7, 10'd3, 4'h2));
`ifdef SAL_BK_CLOSED_PAGE_EN
        exp_q.push_back(mk_cmd(CmdPre, 4'h0, 14'd7, 10'd0, 4'h0));
`endif
        n = exp_q.size();
        send_req(4'h4, 14'd7, 10'd3, 4'h2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vec++;
            if ({bus.cmd_valid, bus.cmd_op, bus.cmd_id, bus.cmd_ra, bus.cmd_ca, bus.cmd_len} !==
                {1'b1, CmdAct, 4'h0, 14'd7, 10'd0, 4'h0}) begin
                mis++;
                $display("FAIL bp_stable%0d: got v=%b op=%0d ra=%h want v=1 op=0 ra=7",
                         i, bus.cmd_valid, bus.cmd_op, bus.cmd_ra);
            end
        end
        @(posedge clk);
        #1 bus.cmd_ready = 1'b1;
        wait_obs(n, ok);
        repeat (30) @(posedge clk);
        vec++;
        if (!ok || obs_q.size() != n) begin
            mis++; $display("FAIL bp_count: got %0d cmds want %0d", obs_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                o = obs_q.pop_front(); e = exp_q.pop_front(); vec++;
                if (o.c !== e) begin mis++; $display("FAIL bp cmd%0d: got %h want %h", i, o.c, e); end
            end
        end
    endtask

    task automatic test_closed_page();
        bit ok; obs_t o; cmd_t e; int ed[3];
        apply_reset();
        exp_q.push_back(mk_cmd(CmdAct, 4'h0, 14'd5, 10'd0, 4'h0));
        exp_q.push_back(mk_cmd(CmdWr, 4'h5, 14'd5, 10'd4, 4'h1));
        exp_q.push_back(mk_cmd(CmdPre, 4'h0, 14'd5, 10'd0, 4'h0));
        send_req(4'h5, 14'd5, 10'd4, 4'h1, 1'b1);
        wait_obs(3, ok);
        if (!ok) begin
            vec++; mis++; $display("FAIL closed_page: got %0d cmds want 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                o = obs_q.pop_front(); e = exp_q.pop_front(); ed[i] = o.edge_n; vec++;
                if (o.c !== e) begin mis++; $display("FAIL closed_page cmd%0d: got %h want %h", i, o.c, e); end
            end
            vec++; if (ed[2] - ed[1] != 6) begin mis++; $display("FAIL closed_page wtp: got %0d want 6", ed[2] - ed[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_read_closed();
        test_backpressure();
`ifdef SAL_BK_CLOSED_PAGE_EN
        test_closed_page();
`else
        test_row_hit();
        test_row_miss();
        test_refresh();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
